bsg_global_buffer_ro_row_client: RTL

- Per-row client-side front end for the read-only global-buffer ring network.
- Takes read requests from a client over a valid/ready handshake and drives them into one network row (v, addr) through a registered request stage.
- Read data returns from the network with no backpressure. It is captured in a local response FIFO, and the client drains that FIFO with a valid/yumi handshake.
- A credit counter guarantees the FIFO can never overflow, so the no-backpressure network is never stalled.

---
 rtl/bsg_global_buffer_ro_row_client_if.sv | 32 +++
 rtl/bsg_global_buffer_ro_row_client.sv | 126 ++++++++++++
 2 files changed

// File: rtl/bsg_global_buffer_ro_row_client_if.sv
// Client/network-row signal bundle for bsg_global_buffer_ro_row_client.
// The slave modport is the row client; the master modport is the client plus network side.
interface bsg_global_buffer_ro_row_client_if #(
    parameter int unsigned data_width_p       = 32,
    parameter int unsigned ro_wo_addr_width_p = 16,
    parameter int unsigned resp_els_p         = 4
);
    localparam int unsigned CNT_W = $clog2(resp_els_p + 1);

    logic [ro_wo_addr_width_p-1:0] req_addr_i;
    logic                          req_v_i;
    logic                          req_ready_o;
    logic [ro_wo_addr_width_p-1:0] net_addr_o;
    logic                          net_v_o;
    logic [data_width_p-1:0]       net_data_i;
    logic                          net_v_i;
    logic [data_width_p-1:0]       resp_data_o;
    logic                          resp_v_o;
    logic                          resp_yumi_i;
    logic [CNT_W-1:0]              credits_o;
    logic                          err_o;

    modport slave (
        input  req_addr_i, req_v_i, net_data_i, net_v_i, resp_yumi_i,
        output req_ready_o, net_addr_o, net_v_o, resp_data_o, resp_v_o, credits_o, err_o
    );

    modport master (
        output req_addr_i, req_v_i, net_data_i, net_v_i, resp_yumi_i,
        input  req_ready_o, net_addr_o, net_v_o, resp_data_o, resp_v_o, credits_o, err_o
    );
endinterface

// File: rtl/bsg_global_buffer_ro_row_client.sv
// Per-row read-only global-buffer client: credit-gated request stage plus response FIFO.
// Define BSG_GLOBAL_BUFFER_RO_RESP_BYPASS_EN for zero-latency return when the FIFO is empty.
module bsg_global_buffer_ro_row_client #(
    parameter int unsigned data_width_p       = 32,
    parameter int unsigned ro_wo_addr_width_p = 16,
    parameter int unsigned resp_els_p         = 4
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    bsg_global_buffer_ro_row_client_if.slave    bus
);
    localparam int unsigned CNT_W = $clog2(resp_els_p + 1);
    localparam int unsigned PTR_W = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;

    logic [CNT_W-1:0]              r_cred;
    logic [CNT_W-1:0]              r_outs;
    logic [CNT_W-1:0]              r_count;
    logic [PTR_W-1:0]              r_rptr;
    logic [PTR_W-1:0]              r_wptr;
    logic                          r_net_v;
    logic [ro_wo_addr_width_p-1:0] r_net_addr;
    logic                          r_err;
    logic [data_width_p-1:0]       r_mem [resp_els_p];

    logic                          w_ready;
    logic                          w_accept;
    logic                          w_empty;
    logic                          w_full;
    logic                          w_resp_v;
    logic                          w_deq;
    logic                          w_byp_take;
    logic                          w_yumi_ok;
    logic                          w_enq;
    logic                          w_err_set;
    logic [CNT_W-1:0]              w_cred_n;
    logic [CNT_W-1:0]              w_outs_n;
    logic [CNT_W-1:0]              w_count_n;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(resp_els_p - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_ready  = (r_cred != '0);
    assign w_accept = bus.req_v_i & w_ready;
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_W'(resp_els_p));

`ifdef BSG_GLOBAL_BUFFER_RO_RESP_BYPASS_EN
    // Empty FIFO forwards the arriving word; a same-cycle yumi keeps it out of storage.
    assign w_byp_take      = w_empty & bus.net_v_i & bus.resp_yumi_i;
    assign w_resp_v        = ~w_empty | bus.net_v_i;
    assign bus.resp_data_o = (w_empty & bus.net_v_i) ? bus.net_data_i : r_mem[r_rptr];
`else
    assign w_byp_take      = 1'b0;
    assign w_resp_v        = ~w_empty;
    assign bus.resp_data_o = r_mem[r_rptr];
`endif

    assign w_deq     = bus.resp_yumi_i & ~w_empty;
    assign w_yumi_ok = bus.resp_yumi_i & w_resp_v;
    assign w_enq     = bus.net_v_i & ~w_byp_take & (~w_full | w_deq);
    assign w_err_set = (bus.net_v_i & (r_outs == '0))
                     | (bus.net_v_i & w_full & ~bus.resp_yumi_i)
                     | (bus.resp_yumi_i & ~w_resp_v);

    // Counter next-state: simultaneous increment and decrement cancel.
    always_comb begin
        w_cred_n  = r_cred;
        w_outs_n  = r_outs;
        w_count_n = r_count;
        if (w_accept & ~w_yumi_ok) begin
            w_cred_n = r_cred - CNT_W'(1);
        end else if (~w_accept & w_yumi_ok) begin
            w_cred_n = r_cred + CNT_W'(1);
        end
        if (r_net_v & ~bus.net_v_i) begin
            w_outs_n = r_outs + CNT_W'(1);
        end else if (~r_net_v & bus.net_v_i & (r_outs != '0)) begin
            w_outs_n = r_outs - CNT_W'(1);
        end
        if (w_enq & ~w_deq) begin
            w_count_n = r_count + CNT_W'(1);
        end else if (~w_enq & w_deq) begin
            w_count_n = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cred     <= CNT_W'(resp_els_p);
            r_outs     <= '0;
            r_count    <= '0;
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_net_v    <= 1'b0;
            r_net_addr <= '0;
            r_err      <= 1'b0;
            for (int i = 0; i < int'(resp_els_p); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_cred  <= w_cred_n;
            r_outs  <= w_outs_n;
            r_count <= w_count_n;
            r_net_v <= w_accept;
            r_err   <= r_err | w_err_set;
            if (w_accept) begin
                r_net_addr <= bus.req_addr_i;
            end
            if (w_enq) begin
                r_mem[r_wptr] <= bus.net_data_i;
                r_wptr        <= next_ptr(r_wptr);
            end
            if (w_deq) begin
                r_rptr <= next_ptr(r_rptr);
            end
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.net_v_o     = r_net_v;
    assign bus.net_addr_o  = r_net_addr;
    assign bus.resp_v_o    = w_resp_v;
    assign bus.credits_o   = r_cred;
    assign bus.err_o       = r_err;
endmodule
